bsg_manycore_mem_responder: RTL and testbench
=============================================

BSG_MANYCORE_MEM_RESPONDER -- requirements
Module: bsg_manycore_mem_responder

Interface
REQ-001 The block SHALL have these parameters:
- data_width_p, default 32: word width in bits.
- addr_width_p, default 28: endpoint word-address width.
- x_cord_width_p, default 4: packet X coordinate width.
- y_cord_width_p, default 3: packet Y coordinate width.
- mem_els_p, default 1024: backing-store depth in words.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk_i, in, 1: the single clock.
- reset_n_i, in, 1: asynchronous, active-low reset.
- req_v_i, in, 1: request valid.
- req_ready_o, out, 1: request ready; a transfer occurs when valid and ready are both high.
- req_op_i, in, 2: operation; 0 load, 1 store, 2 masked store, 3 amoswap.
- req_addr_i, in, addr_width_p: word address.
- req_data_i, in, data_width_p: write data.
- req_mask_i, in, data_width_p/8: byte mask.
- req_src_x_i, in, x_cord_width_p: source X coordinate.
- req_src_y_i, in, y_cord_width_p: source Y coordinate.
- req_reg_id_i, in, 5: requester tag.
- resp_v_o, out, 1: response valid.
- resp_yumi_i, in, 1: consumer accepts the response this cycle.
- resp_type_o, out, 1: response type; 0 write-ack, 1 load-data.
- resp_data_o, out, data_width_p: response data.
- resp_reg_id_o, out, 5: tag echoed from the request.
- resp_dst_x_o, out, x_cord_width_p: request source X.
- resp_dst_y_o, out, y_cord_width_p: request source Y.
- resp_err_o, out, 1: address was out of range.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready_o SHALL equal (state==IDLE).
REQ-004 In IDLE, a request handshake SHALL latch every request field and move to ACCESS.
REQ-005 In ACCESS, the block SHALL perform the operation on the 1-read/1-write synchronous memory:
- load: read.
- store: write the full word.
- masked store: write only the bytes with mask bit 1.
- amoswap: read the old word and write req_data in the same cycle.
REQ-006 ACCESS SHALL always last exactly one cycle and then go to RESP.
REQ-007 In RESP, the block SHALL enqueue one response into the 2-entry response FIFO when it has space and then return to IDLE; if the FIFO is full it SHALL hold in RESP.
REQ-008 Response contents:
- load and amoswap: resp_type=1, resp_data = word read before any write in the same ACCESS cycle.
- store and masked store: resp_type=0, resp_data=0.
REQ-009 The reg_id and src x/y SHALL be echoed unchanged into the response.
REQ-010 An address >= mem_els_p SHALL NOT modify memory; it SHALL still produce a response with resp_err_o=1, and load or amoswap data SHALL be 0.
REQ-011 Latency: request handshake at cycle N gives resp_v_o=1 at cycle N+2 when the FIFO is empty; peak throughput is one request per 3 cycles.
REQ-012 resp_v_o SHALL be high exactly when the FIFO is non-empty; resp_yumi_i SHALL only be asserted while resp_v_o=1, and it pops one entry.
REQ-013 Simultaneous enqueue and dequeue on a full FIFO SHALL NOT be allowed; RESP waits one cycle. Simultaneous enqueue and dequeue on a 1-entry FIFO SHALL leave it at 1 entry.
REQ-014 Requests SHALL be answered strictly in acceptance order; each accepted request SHALL produce exactly one response.
REQ-015 A masked store with mask 0 SHALL leave memory unchanged and still produce an ack.

Reset
REQ-016 While reset_n_i=0 the block SHALL hold: state=IDLE, FIFO empty, req_ready_o=0, resp_v_o=0, all response outputs 0.
REQ-017 Reset assertion mid-operation SHALL discard the in-flight request and all queued responses immediately, without waiting for a clock.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 req_ready_o SHALL be 1 on the first clock edge after reset deasserts.

Structure
REQ-020 The op encoding (e_mem_resp_op_load, _store, _store_mask, _amoswap) and response-type enum SHALL live in bsg_manycore_pkg.
REQ-021 The response buffer SHALL be an instance of bsg_two_fifo.
REQ-022 The memory SHALL be bsg_mem_1rw_sync_mask_write_byte, with read-before-write emulated by a registered read and a write in the following cycle; the ACCESS timing of REQ-006 SHALL still hold externally.

Verification
REQ-023 Store addr 5 data 0xDEADBEEF, then load addr 5 -> ack type 0, then type 1 data 0xDEADBEEF, same reg_id and coordinates echoed.
REQ-024 Masked store mask 4'b0101 data 0x11223344 over word 0xAABBCCDD at addr 7, then load -> 0xAA22CC44.
REQ-025 Amoswap addr 9 (holding 0x1) with 0x2 -> response 0x1; a following load -> 0x2.
REQ-026 Load addr mem_els_p -> err=1, data=0; memory unchanged.
REQ-027 Hold resp_yumi_i=0 and issue 3 requests -> two responses queued, FSM stalls in RESP, req_ready_o=0; releasing yumi drains all 3 in order.
REQ-028 Assert reset_n_i=0 while in ACCESS -> resp_v_o=0 immediately; req_ready_o=1 after release; the next request completes normally.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared encodings for the manycore memory responder: request ops,
// response types and responder FSM states.
package bsg_manycore_pkg;

  typedef enum logic [1:0] {
    e_mem_resp_op_load       = 2'd0,
    e_mem_resp_op_store      = 2'd1,
    e_mem_resp_op_store_mask = 2'd2,
    e_mem_resp_op_amoswap    = 2'd3
  } bsg_mem_resp_op_e;

  typedef enum logic {
    e_resp_type_write_ack = 1'b0,
    e_resp_type_load_data = 1'b1
  } bsg_resp_type_e;

  typedef enum logic [1:0] {
    e_state_idle   = 2'd0,
    e_state_access = 2'd1,
    e_state_resp   = 2'd2
  } mem_resp_state_e;

  function automatic logic op_returns_data(input bsg_mem_resp_op_e op);
    return (op == e_mem_resp_op_load) || (op == e_mem_resp_op_amoswap);
  endfunction

  function automatic logic op_is_store(input bsg_mem_resp_op_e op);
    return (op == e_mem_resp_op_store) || (op == e_mem_resp_op_store_mask);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with byte write enables; a read registers
// data_o, which then holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int els_p        = 1024,
  parameter int data_width_p = 32,
  parameter int addr_width_p = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      v_i,
  input  logic                      w_i,
  input  logic [addr_width_p-1:0]   addr_i,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [data_width_p/8-1:0] write_mask_i,
  output logic [data_width_p-1:0]   data_o
);

  localparam int mask_width_lp = data_width_p / 8;

  logic [data_width_p-1:0] r_mem [els_p];
  logic [data_width_p-1:0] r_data;

  // NOTE: the array and read register have no reset; contents survive reset_n_i.
  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        for (int b = 0; b < mask_width_lp; b++) begin
          if (write_mask_i[b]) r_mem[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
        end
      end else begin
        r_data <= r_mem[addr_i];
      end
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready-in, valid/yumi-out FIFO. ready_o means "not full",
// so an enqueue into a full FIFO is refused even if a dequeue happens.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Manycore memory endpoint: accepts one request at a time, performs it on a
// single-port RAM and queues the response in a two-entry FIFO.
module bsg_manycore_mem_responder
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 3,
  parameter int mem_els_p      = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [data_width_p/8-1:0] req_mask_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  input  logic [4:0]                req_reg_id_i,
  output logic                      resp_v_o,
  input  logic                      resp_yumi_i,
  output logic                      resp_type_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic [4:0]                resp_reg_id_o,
  output logic [x_cord_width_p-1:0] resp_dst_x_o,
  output logic [y_cord_width_p-1:0] resp_dst_y_o,
  output logic                      resp_err_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int mem_addr_w_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int resp_width_lp = 2 + 5 + x_cord_width_p + y_cord_width_p + data_width_p;
  localparam logic [addr_width_p-1:0] mem_els_lp = addr_width_p'(mem_els_p);

  mem_resp_state_e             r_state, w_state_n;
  bsg_mem_resp_op_e            r_op;
  logic [addr_width_p-1:0]     r_addr;
  logic [data_width_p-1:0]     r_data;
  logic [mask_width_lp-1:0]    r_mask;
  logic [x_cord_width_p-1:0]   r_src_x;
  logic [y_cord_width_p-1:0]   r_src_y;
  logic [4:0]                  r_reg_id;
  logic                        r_wb_pending;

  logic                        w_req_fire;
  logic                        w_in_range;
  logic                        w_enq;
  logic                        w_fifo_ready;
  logic                        w_fifo_v;
  logic [resp_width_lp-1:0]    w_fifo_in;
  logic [resp_width_lp-1:0]    w_fifo_out;
  logic [resp_width_lp-1:0]    w_head;
  logic                        w_mem_v;
  logic                        w_mem_w;
  logic [mask_width_lp-1:0]    w_mem_mask;
  logic [data_width_p-1:0]     w_mem_rdata;
  logic [data_width_p-1:0]     w_resp_data;

  assign req_ready_o = reset_n_i & (r_state == e_state_idle);
  assign w_req_fire  = req_v_i & req_ready_o;
  assign w_in_range  = (r_addr < mem_els_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= e_state_idle;
      r_wb_pending <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      // amoswap read happens in ACCESS; its write lands in the first RESP cycle
      r_wb_pending <= (r_state == e_state_access) && (r_op == e_mem_resp_op_amoswap)
                      && w_in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_req_fire) begin
      r_op     <= bsg_mem_resp_op_e'(req_op_i);
      r_addr   <= req_addr_i;
      r_data   <= req_data_i;
      r_mask   <= req_mask_i;
      r_src_x  <= req_src_x_i;
      r_src_y  <= req_src_y_i;
      r_reg_id <= req_reg_id_i;
    end
  end

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    w_state_n = r_state;
    w_enq     = 1'b0;
    case (r_state)
      e_state_idle:   if (req_v_i) w_state_n = e_state_access;
      e_state_access: w_state_n = e_state_resp;
      e_state_resp: begin
        w_enq = 1'b1;
        if (w_fifo_ready) w_state_n = e_state_idle;
      end
      default:        w_state_n = e_state_idle;
    endcase
  end

  assign w_mem_v    = w_in_range & ((r_state == e_state_access) | r_wb_pending);
  assign w_mem_w    = (r_state != e_state_access) | op_is_store(r_op);
  assign w_mem_mask = ((r_state == e_state_access) && (r_op == e_mem_resp_op_store_mask))
                      ? r_mask : '1;

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (mem_els_p),
    .data_width_p (data_width_p),
    .addr_width_p (mem_addr_w_lp)
  ) u_mem (
    .clk_i        (clk_i),
    .v_i          (w_mem_v),
    .w_i          (w_mem_w),
    .addr_i       (r_addr[mem_addr_w_lp-1:0]),
    .data_i       (r_data),
    .write_mask_i (w_mem_mask),
    .data_o       (w_mem_rdata)
  );

  assign w_resp_data = (op_returns_data(r_op) && w_in_range) ? w_mem_rdata : '0;
  assign w_fifo_in   = {op_returns_data(r_op), ~w_in_range, r_reg_id,
                        r_src_x, r_src_y, w_resp_data};

  bsg_two_fifo #(
    .width_p   (resp_width_lp)
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .ready_o   (w_fifo_ready),
    .v_i       (w_enq),
    .data_i    (w_fifo_in),
    .v_o       (w_fifo_v),
    .data_o    (w_fifo_out),
    .yumi_i    (resp_yumi_i)
  );

  // Head fields are forced to zero whenever nothing is queued, including reset.
  assign w_head   = w_fifo_v ? w_fifo_out : '0;
  assign resp_v_o = w_fifo_v;
  assign {resp_type_o, resp_err_o, resp_reg_id_o,
          resp_dst_x_o, resp_dst_y_o, resp_data_o} = w_head;

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Self-checking bench: table of request vectors feeding a response
// scoreboard, plus hand-written latency, back-pressure and reset sequences.
module tb_bsg_manycore_mem_responder;
  import bsg_manycore_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 28;
  localparam int XW  = 4;
  localparam int YW  = 3;
  localparam int ELS = 1024;

  typedef struct packed {
    logic          typ;
    logic          err;
    logic [4:0]    reg_id;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    mask;
    logic          exp_type;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          req_v_i;
  logic          req_ready_o;
  logic [1:0]    req_op_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_data_i;
  logic [3:0]    req_mask_i;
  logic [XW-1:0] req_src_x_i;
  logic [YW-1:0] req_src_y_i;
  logic [4:0]    req_reg_id_i;
  logic          resp_v_o;
  logic          resp_yumi_i;
  logic          resp_type_o;
  logic [DW-1:0] resp_data_o;
  logic [4:0]    resp_reg_id_o;
  logic [XW-1:0] resp_dst_x_o;
  logic [YW-1:0] resp_dst_y_o;
  logic          resp_err_o;

  logic          yumi_en;
  int            checks = 0;
  int            errors = 0;
  int            n_resp = 0;
  resp_t         sb[$];
  vec_t          vecs[23];

  bsg_manycore_mem_responder #(
    .data_width_p   (DW),
    .addr_width_p   (AW),
    .x_cord_width_p (XW),
    .y_cord_width_p (YW),
    .mem_els_p      (ELS)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .req_v_i       (req_v_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_mask_i    (req_mask_i),
    .req_src_x_i   (req_src_x_i),
    .req_src_y_i   (req_src_y_i),
    .req_reg_id_i  (req_reg_id_i),
    .resp_v_o      (resp_v_o),
    .resp_yumi_i   (resp_yumi_i),
    .resp_type_o   (resp_type_o),
    .resp_data_o   (resp_data_o),
    .resp_reg_id_o (resp_reg_id_o),
    .resp_dst_x_o  (resp_dst_x_o),
    .resp_dst_y_o  (resp_dst_y_o),
    .resp_err_o    (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  assign resp_yumi_i = yumi_en & resp_v_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [3:0] mask,
                      input logic [4:0] tag, input logic [XW-1:0] x,
                      input logic [YW-1:0] y, input resp_t exp, input bit push);
    bit accepted = 1'b0;
    if (push) sb.push_back(exp);
    @(posedge clk_i); #2;
    req_op_i = op; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
    req_reg_id_i = tag; req_src_x_i = x; req_src_y_i = y; req_v_i = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        accepted = 1'b1;
        @(posedge clk_i); #2;
      end
    end
    req_v_i = 1'b0;
    check("req_accepted", accepted, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  function automatic resp_t mk(input logic typ, input logic [DW-1:0] d, input logic err,
                               input logic [4:0] tag, input logic [XW-1:0] x,
                               input logic [YW-1:0] y);
    resp_t r;
    r.typ = typ; r.err = err; r.reg_id = tag; r.x = x; r.y = y; r.data = d;
    return r;
  endfunction

  // Scoreboard: every popped response must match the oldest expectation.
  always @(negedge clk_i) begin
    resp_t act;
    if (reset_n_i === 1'b1 && resp_v_o && resp_yumi_i) begin
      act = {resp_type_o, resp_err_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o, resp_data_o};
      if (sb.size() == 0) begin
        check("resp_unexpected_queue_size", sb.size(), 1);
      end else begin
        check($sformatf("resp_%0d", n_resp), act, sb.pop_front());
      end
      n_resp++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd1, 28'd5,         32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{2'd0, 28'd5,         32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{2'd1, 28'd7,         32'hAABBCCDD, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{2'd2, 28'd7,         32'h11223344, 4'h5, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{2'd0, 28'd7,         32'h0,        4'hF, 1'b1, 32'hAA22CC44, 1'b0};
    vecs[5]  = '{2'd1, 28'd9,         32'h1,        4'hF, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{2'd3, 28'd9,         32'h2,        4'hF, 1'b1, 32'h1,        1'b0};
    vecs[7]  = '{2'd0, 28'd9,         32'h0,        4'hF, 1'b1, 32'h2,        1'b0};
    vecs[8]  = '{2'd1, 28'd0,         32'h0BADF00D, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{2'd0, 28'd1024,      32'h0,        4'hF, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{2'd1, 28'd1024,      32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1};
    vecs[11] = '{2'd3, 28'd1024,      32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        1'b1};
    vecs[12] = '{2'd0, 28'd0,         32'h0,        4'hF, 1'b1, 32'h0BADF00D, 1'b0};
    vecs[13] = '{2'd2, 28'd5,         32'h00000000, 4'h0, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{2'd0, 28'd5,         32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[15] = '{2'd1, 28'd1023,      32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[16] = '{2'd0, 28'd1023,      32'h0,        4'hF, 1'b1, 32'h12345678, 1'b0};
    vecs[17] = '{2'd3, 28'd0,         32'hCAFE0000, 4'hF, 1'b1, 32'h0BADF00D, 1'b0};
    vecs[18] = '{2'd0, 28'd0,         32'h0,        4'hF, 1'b1, 32'hCAFE0000, 1'b0};
    vecs[19] = '{2'd2, 28'd1023,      32'h99000000, 4'h8, 1'b0, 32'h0,        1'b0};
    vecs[20] = '{2'd0, 28'd1023,      32'h0,        4'hF, 1'b1, 32'h99345678, 1'b0};
    vecs[21] = '{2'd0, 28'hFFFFFFF,   32'h0,        4'hF, 1'b1, 32'h0,        1'b1};
    vecs[22] = '{2'd1, 28'd1025,      32'h5A5A5A5A, 4'hF, 1'b0, 32'h0,        1'b1};

    reset_n_i = 1'b0; req_v_i = 1'b0; yumi_en = 1'b1;
    req_op_i = '0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
    req_src_x_i = '0; req_src_y_i = '0; req_reg_id_i = '0;

    repeat (3) @(negedge clk_i);
    check("reset_req_ready", req_ready_o, 0);
    check("reset_resp_v", resp_v_o, 0);
    check("reset_resp_fields", {resp_type_o, resp_err_o, resp_reg_id_o,
                                resp_dst_x_o, resp_dst_y_o, resp_data_o}, 0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("ready_after_reset", req_ready_o, 1);

    // Vector table
    for (int i = 0; i < 23; i++) begin
      send(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask,
           5'(i), XW'(i), YW'(i + 3),
           mk(vecs[i].exp_type, vecs[i].exp_data, vecs[i].exp_err, 5'(i), XW'(i), YW'(i + 3)),
           1'b1);
    end
    drain();

    // Latency: handshake edge N, resp_v_o first high after edge N+2
    send(2'd0, 28'd5, 32'h0, 4'hF, 5'd25, 4'd9, 3'd6,
         mk(1'b1, 32'hDEADBEEF, 1'b0, 5'd25, 4'd9, 3'd6), 1'b1);
    @(negedge clk_i);
    check("latency_access_v", resp_v_o, 0);
    @(negedge clk_i);
    check("latency_resp_v", resp_v_o, 0);
    @(negedge clk_i);
    check("latency_n_plus_2_v", resp_v_o, 1);
    drain();

    // Back-pressure: two queued, third stalls in RESP, then in-order drain
    yumi_en = 1'b0;
    send(2'd1, 28'd40, 32'hA0A0A0A0, 4'hF, 5'd20, 4'd1, 3'd1,
         mk(1'b0, 32'h0, 1'b0, 5'd20, 4'd1, 3'd1), 1'b1);
    send(2'd1, 28'd41, 32'hB1B1B1B1, 4'hF, 5'd21, 4'd2, 3'd2,
         mk(1'b0, 32'h0, 1'b0, 5'd21, 4'd2, 3'd2), 1'b1);
    send(2'd0, 28'd40, 32'h0, 4'hF, 5'd22, 4'd3, 3'd3,
         mk(1'b1, 32'hA0A0A0A0, 1'b0, 5'd22, 4'd3, 3'd3), 1'b1);
    repeat (3) @(negedge clk_i);
    check("stall_resp_v", resp_v_o, 1);
    check("stall_req_ready", req_ready_o, 0);
    check("stall_head_tag", resp_reg_id_o, 20);
    repeat (3) @(negedge clk_i);
    check("stall_req_ready_still", req_ready_o, 0);
    @(posedge clk_i); #2;
    yumi_en = 1'b1;
    drain();

    // Reset during ACCESS with a queued response
    yumi_en = 1'b0;
    send(2'd1, 28'd50, 32'hC3C3C3C3, 4'hF, 5'd26, 4'd4, 3'd4, '0, 1'b0);
    repeat (3) @(negedge clk_i);
    send(2'd0, 28'd40, 32'h0, 4'hF, 5'd27, 4'd5, 3'd5, '0, 1'b0);
    reset_n_i = 1'b0;
    #1;
    check("midreset_resp_v", resp_v_o, 0);
    check("midreset_req_ready", req_ready_o, 0);
    check("midreset_resp_fields", {resp_type_o, resp_err_o, resp_reg_id_o,
                                   resp_dst_x_o, resp_dst_y_o, resp_data_o}, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("ready_after_midreset", req_ready_o, 1);
    yumi_en = 1'b1;
    send(2'd0, 28'd40, 32'h0, 4'hF, 5'd28, 4'd6, 3'd7,
         mk(1'b1, 32'hA0A0A0A0, 1'b0, 5'd28, 4'd6, 3'd7), 1'b1);
    send(2'd0, 28'd50, 32'h0, 4'hF, 5'd29, 4'd7, 3'd0,
         mk(1'b1, 32'hC3C3C3C3, 1'b0, 5'd29, 4'd7, 3'd0), 1'b1);
    drain();
    repeat (4) @(negedge clk_i);
    check("final_resp_v", resp_v_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
